// File: rtl/hazard_ctrl.sv
// Purpose : pipeline sequencer for the 5-stage RV32 core; drives per-stage stall/flush/bubble controls.
// Latency : controls are combinational from current state and inputs; state/counters update on the next clk edge.
// Backpr. : a data-memory wait freezes PC..EX/MEM and bubbles MEM/WB, holding off redirect and load-use actions.
// Optional: define HAZARD_PERF_CNT_EN to add the perf_stall_cycles / perf_flushes / perf_load_use counters.
module hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 2,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        ex_redirect,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        bubble_mem_wb,
    output logic [1:0]  state,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_load_use
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // Counter reload after a redirect: the redirect cycle itself is the first flush.
    localparam logic [3:0]  REDIR_LOAD = 4'(REDIRECT_BUBBLES - 1);
    localparam logic [15:0] TO_VAL     = 16'(MEM_TIMEOUT);
    localparam logic [15:0] WAIT_MAX   = 16'hFFFF;

    state_t      state_q;
    logic [3:0]  redir_cnt;
    logic [15:0] wait_cnt;
    logic        timeout_q;

    logic load_use;
    logic mem_stall;
    logic in_redirect;
    logic act_redirect;
    logic act_load_use;
    logic hold_flush;

    // Hazard classification and priority resolution (mem_stall > redirect > load_use).
    always_comb begin
        load_use     = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
                       ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
        mem_stall    = mem_req & ~mem_ready;
        // Encoding 3 is unreachable; anything other than REDIRECT behaves as RUN.
        in_redirect  = (state_q == ST_REDIRECT);
        act_redirect = ~mem_stall & ex_redirect;
        // ID holds a bubble during refill, so a load-use match there is meaningless.
        act_load_use = ~mem_stall & ~ex_redirect & ~in_redirect & load_use;
        hold_flush   = ~mem_stall & ~ex_redirect & in_redirect;
    end

    // Per-stage control outputs derived from the resolved action.
    always_comb begin
        stall_pc      = mem_stall | act_load_use;
        stall_if_id   = mem_stall | act_load_use;
        stall_id_ex   = mem_stall;
        stall_ex_mem  = mem_stall;
        bubble_mem_wb = mem_stall;
        flush_if_id   = act_redirect | hold_flush;
        flush_id_ex   = act_redirect | act_load_use;
        state         = state_q;
        mem_timeout   = timeout_q;
    end

    // Sequencer state, refill counter, memory-wait counter and sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            redir_cnt <= 4'd0;
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else if (mem_stall) begin
            // Frozen pipeline: refill counter holds, wait counter keeps running.
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (wait_cnt == TO_VAL) begin
                timeout_q <= 1'b1;
            end
            if (!in_redirect) begin
                state_q <= ST_MEM_WAIT;
            end
        end else begin
            wait_cnt <= 16'd0;
            if (ex_redirect) begin
                if (REDIRECT_BUBBLES > 1) begin
                    state_q   <= ST_REDIRECT;
                    redir_cnt <= REDIR_LOAD;
                end else begin
                    state_q   <= ST_RUN;
                    redir_cnt <= 4'd0;
                end
            end else if (in_redirect) begin
                if (redir_cnt <= 4'd1) begin
                    state_q   <= ST_RUN;
                    redir_cnt <= 4'd0;
                end else begin
                    redir_cnt <= redir_cnt - 4'd1;
                end
            end else begin
                state_q <= ST_RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
            perf_load_use     <= 32'd0;
        end else begin
            if (stall_pc) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (act_redirect) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
            if (act_load_use) begin
                perf_load_use <= perf_load_use + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a reference model of owed flushes and stall run length.
module tb_hazard_ctrl;

    localparam int RB = 3;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read;
    logic        mem_req, mem_ready, ex_redirect;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        flush_if_id, flush_id_ex, bubble_mem_wb;
    logic [1:0]  state;
    logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

    hazard_ctrl #(.REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_req(mem_req), .mem_ready(mem_ready), .ex_redirect(ex_redirect),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .bubble_mem_wb(bubble_mem_wb), .state(state), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes(perf_flushes),
        .perf_load_use(perf_load_use)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: flush cycles still owed, consecutive stalled cycles so far, sticky timeout.
    int owed   = 0;
    int waited = 0;
    bit m_to   = 1'b0;
    int p_stall = 0, p_flush = 0, p_lu = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, bubble_mem_wb};
    endfunction

    task automatic model_reset();
        owed = 0; waited = 0; m_to = 1'b0;
        p_stall = 0; p_flush = 0; p_lu = 0;
    endtask

    task automatic drive_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; ex_redirect = 1'b0;
    endtask

    // One cycle: drive after the falling edge, check mid-low-phase, advance model at the rising edge.
    task automatic cyc(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic lr,
                       input logic mq, input logic my, input logic rdr);
        bit         ms, lu;
        logic [6:0] exp_o;
        int         exp_st;
        @(negedge clk);
        id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_reg_write = rw; ex_mem_read = lr;
        mem_req = mq; mem_ready = my; ex_redirect = rdr;
        #2;
        ms = mq && !my;
        lu = lr && rw && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        exp_st = (owed > 0) ? 2 : ((waited > 0) ? 1 : 0);
        if (ms)             exp_o = 7'b1111001;
        else if (rdr)       exp_o = 7'b0000110;
        else if (owed > 0)  exp_o = 7'b0000100;
        else if (lu)        exp_o = 7'b1100010;
        else                exp_o = 7'b0000000;
        check_eq("ctrl_outs", 32'(outs()), 32'(exp_o));
        check_eq("state", 32'(state), exp_st);
        check_eq("mem_timeout", 32'(mem_timeout), 32'(m_to));
        @(posedge clk);
        if (ms) begin
            if (waited == TO) m_to = 1'b1;
            if (waited < 65535) waited++;
            p_stall++;
        end else begin
            waited = 0;
            if (rdr) begin
                owed = RB - 1;
                p_flush++;
            end else if (owed > 0) begin
                owed--;
            end else if (lu) begin
                p_lu++;
                p_stall++;
            end
        end
    endtask

    task automatic idle_cyc();
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset landing mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        drive_idle();
        #1 rst = 1'b1;
        #1;
        check_eq({tag, "_state"}, 32'(state), 32'd0);
        check_eq({tag, "_outs"}, 32'(outs()), 32'd0);
        check_eq({tag, "_timeout"}, 32'(mem_timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd7;
            default: return 5'd31;
        endcase
    endfunction

    initial begin
        logic [4:0] r1, r2, rd;
        logic       u1, u2, rw, lr, mq, my, rdr;
        int         burst;
        burst = 0;
        drive_idle();
        rst = 1'b1;
        #1;
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_outs", 32'(outs()), 32'd0);
        check_eq("reset_timeout", 32'(mem_timeout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Load-use on rs1, then the same pattern with x0 as destination.
        cyc(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cyc();
        cyc(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Load-use on rs2.
        cyc(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Redirect pulse followed by the refill window.
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) idle_cyc();
        // Four-cycle memory wait, then completion.
        repeat (4) cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_cyc();
        // All three hazards together; redirect held across the memory release.
        repeat (2) cyc(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) idle_cyc();
        // Wait long enough to trip the timeout, release, then confirm it sticks.
        repeat (6) cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_cyc();
        #1 check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);
        // Stall arriving during the refill window, then reset while in REDIRECT.
        cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_eq("mid_redirect_state", 32'(state), 32'd2);
        do_reset("rst_mid_redirect");

        // Randomized traffic with occasional long memory waits and resets.
        for (int i = 0; i < 3000; i++) begin
            r1  = pick_reg();
            r2  = pick_reg();
            rd  = pick_reg();
            u1  = 1'($urandom_range(0, 1));
            u2  = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 3) != 0);
            lr  = 1'($urandom_range(0, 1));
            rdr = ($urandom_range(0, 5) == 0);
            if (burst > 0) begin
                mq = 1'b1;
                my = 1'b0;
                burst--;
            end else begin
                mq = ($urandom_range(0, 3) == 0);
                my = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) burst = $urandom_range(1, 7);
            end
            if ($urandom_range(0, 499) == 0) do_reset("rst_random");
            cyc(r1, r2, u1, u2, rd, rw, lr, mq, my, rdr);
        end

`ifdef HAZARD_PERF_CNT_EN
        #1;
        check_eq("perf_stall_cycles", perf_stall_cycles, 32'(p_stall));
        check_eq("perf_flushes", perf_flushes, 32'(p_flush));
        check_eq("perf_load_use", perf_load_use, 32'(p_lu));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
